shift_exec_stage: RTL
=====================

# shift_exec_stage

Execute-stage wrapper around the combinational shifter in the MIPS core. It:
- accepts decoded SPECIAL-class instructions with their register operands over a valid/ready handshake;
- decodes the six MIPS shift functs and selects the shift amount;
- drives the shifter's A/B/Shiftop inputs from a registered operand stage;
- captures the shifter's result into a 2-entry output buffer that feeds writeback through a second valid/ready handshake.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction/operands present
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction word
- in_rs_data  in  32  GPR[rs]
- in_rt_data  in  32  GPR[rt]
- sh_A  out  32  value to shift (to shifter A)
- sh_B  out  32  shift amount (to shifter B; only [4:0] meaningful)
- sh_Shiftop  out  2  00 sll, 10 srl, 11 sra (to shifter Shiftop)
- sh_Result  in  32  shifter output, combinational from sh_*
- out_valid  out  1  head buffer entry valid
- out_ready  in  1  writeback accepts head
- out_result  out  32  shifted value
- out_waddr  out  5  destination register rd
- out_wen  out  1  register write enable
- out_illegal  out  1  instruction was not a shift

## Operation
- Decode: legal iff in_instr[31:26]==0 and funct in {000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV}.
- Operands:
  - sh_A = rt_data.
  - sh_B = {27'b0, instr[10:6]} when funct[2]==0, else rs_data.
  - sh_Shiftop = funct[1:0].
- Illegal instruction: sh_A = sh_B = 0, sh_Shiftop = 00. Entry carries illegal=1, wen=0, result=0.
- waddr = instr[15:11]. wen = legal && waddr!=0.
- Operand stage (op_v plus registered sh_* and tag) is accepted when in_valid && in_ready.
- advance = op_v && (count<2 || out_ready).
- in_ready = !op_v || advance.
- On advance, {sh_Result (0 if illegal), waddr, wen, illegal} is pushed to the output buffer.
- Output buffer: 2 entries, FIFO order, count 0..2.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle is legal at any count, including count==2.
- out_valid = count!=0. All out_* data fields read 0 while out_valid=0.
- sh_* hold their last value while op_v=0.
- Reset:
  - op_v=0 and count=0.
  - out_valid=0, in_ready=1, all out_* = 0, sh_* = 0.
  - In-flight entries are discarded with no partial output.

## Timing
- Latency: accept at edge k puts the result at the buffer head after edge k+1, provided the buffer was empty.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Backpressure with out_ready=0: two results buffer and one instruction holds in the operand stage. in_ready falls combinationally once op_v=1 and count==2.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists except sh_Result→(buffer input).
- Shift arithmetic: only sh_B[4:0] is used. Amount 0 returns A unchanged. SRA replicates bit 31.

## Configuration
- SHIFT_NOP_SQUASH_EN defined: a legal shift with waddr==0 (including NOP 0x00000000) advances out of the operand stage without pushing to the buffer. It produces no out_valid and never waits on count.
- Undefined: such instructions push a normal entry with wen=0, illegal=0.

## Test plan
- Reset: rst=1 for 2 cycles mid-traffic. Required: out_valid=0, in_ready=1, sh_A=sh_B=0, sh_Shiftop=00. No stale entry appears after rst drops.
- SLL: in_instr=0x00021900 (rd=3, rt=2, sa=4), rt_data=0x000000F1. Required: out_valid one cycle after accept, out_result=0x00000F10, waddr=3, wen=1, illegal=0.
- SRAV: in_instr=0x00E62807 (rs=7, rt=6, rd=5), rs_data=0x00000024, rt_data=0x80000000. Required: sh_B=0x00000024, sh_Shiftop=11, out_result=0xF8000000, waddr=5.
- Backpressure: out_ready=0, four back-to-back SRL issued with sa=1,2,3,4 on rt_data=0x80000000. Required:
  - in_ready=0 after the third accept.
  - Raising out_ready drains 0x40000000, 0x20000000, 0x10000000, 0x08000000 in order, with no loss or duplication.
- Illegal: in_instr=0x00000020 (ADD). Required: out_illegal=1, out_wen=0, out_result=0.
- NOP 0x00000000:
  - With macro: no out_valid.
  - Without macro: one entry with waddr=0, wen=0, illegal=0, result=0.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper around the external combinational shifter: decode, registered
// operand stage, 2-entry result FIFO to writeback. Option macro: SHIFT_NOP_SQUASH_EN.
module shift_exec_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_data,
    input  logic [31:0] in_rt_data,
    output logic [31:0] sh_A,
    output logic [31:0] sh_B,
    output logic [1:0]  sh_Shiftop,
    input  logic [31:0] sh_Result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_waddr,
    output logic        out_wen,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  waddr;
        logic        wen;
        logic        illegal;
    } entry_t;

    logic [5:0]  funct;
    logic        dec_legal;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [1:0]  dec_op;
    logic [4:0]  dec_waddr;
    logic        dec_wen;

    logic        op_v;
    logic [4:0]  op_waddr;
    logic        op_wen;
    logic        op_illegal;

    entry_t      fifo_mem [2];
    entry_t      push_entry;
    entry_t      head_entry;
    logic        head;
    logic [1:0]  count;
    logic        wr_idx;

    logic        accept;
    logic        advance;
    logic        push;
    logic        pop;

    // The legal funct set is {000,010,011,100,110,111}: upper bits zero, low pair never 01.
    assign funct     = in_instr[5:0];
    assign dec_legal = (in_instr[31:26] == 6'd0) && (funct[5:3] == 3'd0) && (funct[1:0] != 2'b01);
    assign dec_waddr = in_instr[15:11];
    assign dec_wen   = dec_legal && (dec_waddr != 5'd0);

    always_comb begin
        dec_a  = '0;
        dec_b  = '0;
        dec_op = 2'b00;
        if (dec_legal) begin
            dec_a  = in_rt_data;
            dec_b  = funct[2] ? in_rs_data : {27'd0, in_instr[10:6]};
            dec_op = funct[1:0];
        end
    end

`ifdef SHIFT_NOP_SQUASH_EN
    // Legal shifts to r0 leave the operand stage without occupying a buffer slot.
    logic op_squash;
    assign advance = op_v && (op_squash || count < 2'd2 || out_ready);
    assign push    = advance && !op_squash;
`else
    assign advance = op_v && (count < 2'd2 || out_ready);
    assign push    = advance;
`endif

    assign in_ready = !op_v || advance;
    assign accept   = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop      = out_valid && out_ready;
    // With count==2 and a pop, the tail slot equals the head slot being vacated.
    assign wr_idx   = head ^ count[0];

    always_comb begin
        push_entry.result  = op_illegal ? '0 : sh_Result;
        push_entry.waddr   = op_waddr;
        push_entry.wen     = op_wen;
        push_entry.illegal = op_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v       <= 1'b0;
            sh_A       <= '0;
            sh_B       <= '0;
            sh_Shiftop <= 2'b00;
            op_waddr   <= '0;
            op_wen     <= 1'b0;
            op_illegal <= 1'b0;
`ifdef SHIFT_NOP_SQUASH_EN
            op_squash  <= 1'b0;
`endif
        end else if (accept) begin
            op_v       <= 1'b1;
            sh_A       <= dec_a;
            sh_B       <= dec_b;
            sh_Shiftop <= dec_op;
            op_waddr   <= dec_waddr;
            op_wen     <= dec_wen;
            op_illegal <= !dec_legal;
`ifdef SHIFT_NOP_SQUASH_EN
            op_squash  <= dec_legal && (dec_waddr == 5'd0);
`endif
        end else if (advance) begin
            op_v <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_idx] <= push_entry;
    end

    always_comb begin
        head_entry = '0;
        if (out_valid)
            head_entry = fifo_mem[head];
    end

    assign out_result  = head_entry.result;
    assign out_waddr   = head_entry.waddr;
    assign out_wen     = head_entry.wen;
    assign out_illegal = head_entry.illegal;

endmodule
